// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and constants for the bit-serial adder.
//   state_e       : FSM state encoding (IDLE, ADD, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADD  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fa.sv
// serial_adder_fa
//   Single-bit full-adder cell; purely combinational.
//   A, B, Cin : input bits
//   Sum       : A ^ B ^ Cin
//   Cout      : majority(A, B, Cin)
module serial_adder_fa (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);

  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held
//   in a flop between cycles. Result registers update only on entry to DONE.
//   Clk      : rising-edge clock
//   Reset    : synchronous active-high reset
//   Start    : begin an addition (sampled in IDLE or DONE only)
//   A, B     : operands, captured when Start is accepted
//   Cin      : carry-in, captured when Start is accepted
//   Busy     : high while in ADD
//   Done     : one-cycle pulse when Sum/Cout/Overflow become valid
//   Sum      : registered result, held until the next completion
//   Cout     : carry out of the MSB
//   Overflow : two's-complement overflow (carry into MSB ^ Cout)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q,  a_sh_d;
  logic [WIDTH-1:0] b_sh_q,  b_sh_d;
  logic [WIDTH-1:0] acc_q,   acc_d;
  logic             carry_q, carry_d;
  logic             cmsb_q,  cmsb_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;
  logic             ovf_q,   ovf_d;

  logic fa_sum;
  logic fa_cout;

  serial_adder_fa u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .Sum  (fa_sum),
    .Cout (fa_cout)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cmsb_d  = cmsb_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        acc_d   = {fa_sum, acc_q[WIDTH-1:1]};
        carry_d = fa_cout;
        // Carry out of bit WIDTH-2 is the carry into the MSB.
        if (cnt_q == CNT_MSB) begin
          cmsb_d = fa_cout;
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          sum_d   = acc_d;
          cout_d  = fa_cout;
          ovf_d   = cmsb_q ^ fa_cout;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state.
    busy_d = (state_d == ADD);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cmsb_q  <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cmsb_q  <= cmsb_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy     = busy_q;
  assign Done     = done_q;
  assign Sum      = sum_q;
  assign Cout     = cout_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8): directed literal cases,
//   then randomized traffic checked every cycle against a behavioural model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         Clk;
  logic         Reset;
  logic         Start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Cin;
  logic         Busy;
  logic         Done;
  logic [W-1:0] Sum;
  logic         Cout;
  logic         Overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .Busy     (Busy),
    .Done     (Done),
    .Sum      (Sum),
    .Cout     (Cout),
    .Overflow (Overflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted request completes W edges later with
  // the arithmetic sum; overflow from the operand/result sign rule.
  int           m_rem  = 0;
  logic [W-1:0] ma     = '0;
  logic [W-1:0] mb     = '0;
  logic         mc     = 1'b0;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
  logic         m_ovf  = 1'b0;
  logic         m_done = 1'b0;
  logic [W:0]   m_tot;

  always @(posedge Clk) begin
    if (Reset) begin
      m_rem  = 0;
      m_done = 1'b0;
      m_sum  = '0;
      m_cout = 1'b0;
      m_ovf  = 1'b0;
    end else if (m_rem > 0) begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      if (m_rem == 0) begin
        m_tot  = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        m_sum  = m_tot[W-1:0];
        m_cout = m_tot[W];
        m_ovf  = (ma[W-1] == mb[W-1]) && (m_sum[W-1] != ma[W-1]);
      end
    end else begin
      m_done = 1'b0;
      if (Start) begin
        ma    = A;
        mb    = B;
        mc    = Cin;
        m_rem = W;
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_busy", Busy,     m_rem > 0);
      chk("cyc_done", Done,     m_done);
      chk("cyc_sum",  Sum,      m_sum);
      chk("cyc_cout", Cout,     m_cout);
      chk("cyc_ovf",  Overflow, m_ovf);
    end
  end

  // Counts negedges until Done is seen (0 on timeout); optionally drops Start
  // after the first edge so only one request is issued.
  task automatic wait_done(input bit drop_start, input bit chk_hold,
                           input logic [W-1:0] prev, output int lat);
    lat = 0;
    for (int i = 1; i <= int'(W) + 4; i++) begin
      @(negedge Clk);
      if (drop_start && i == 1) Start = 1'b0;
      if (Done) begin
        lat = i;
        break;
      end
      if (chk_hold) begin
        chk("hold_sum", Sum, prev);
        chk("hold_busy", Busy, 1'b1);
      end
    end
    if (lat == 0) $display("FAIL done_timeout: got no Done within %0d cycles", W + 4);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic [W-1:0] es, input logic eco, input logic eov);
    logic [W-1:0] prev;
    int lat;
    @(negedge Clk);
    #1;
    A = a; B = b; Cin = c; Start = 1'b1;
    prev = Sum;
    wait_done(1'b1, 1'b1, prev, lat);
    chk("latency",   lat, W + 1);
    chk("lit_sum",   Sum, es);
    chk("lit_cout",  Cout, eco);
    chk("lit_ovf",   Overflow, eov);
    chk("model_sum", m_sum, es);
  endtask

  initial begin
    int lat;
    Reset = 1'b1; Start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk_en = 1'b1;
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_sum",  Sum, '0);
    chk("rst_cout", Cout, 1'b0);
    chk("rst_ovf",  Overflow, 1'b0);
    Reset = 1'b0;

    run_op(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

    // Start held through ADD with changed operands, then a new request in
    // the Done cycle.
    @(negedge Clk);
    #1;
    A = 8'h35; B = 8'h4A; Cin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    A = '0; B = '0;
    wait_done(1'b0, 1'b0, '0, lat);
    chk("held_latency", lat, W);
    chk("held_sum", Sum, 8'h7F);
    A = 8'h01; B = 8'h02; Cin = 1'b1;
    wait_done(1'b1, 1'b0, '0, lat);
    chk("b2b_latency", lat, W + 1);
    chk("b2b_sum", Sum, 8'h04);

    // Reset mid-operation.
    @(negedge Clk);
    #1;
    A = 8'h35; B = 8'h4A; Cin = 1'b0; Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("mid_rst_busy", Busy, 1'b0);
    chk("mid_rst_sum",  Sum, '0);
    chk("mid_rst_cout", Cout, 1'b0);
    chk("mid_rst_ovf",  Overflow, 1'b0);
    for (int i = 0; i < int'(W) + 3; i++) begin
      @(negedge Clk);
      chk("mid_rst_no_done", Done, 1'b0);
    end
    run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

    // Randomized traffic, checked each cycle by the model compare.
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      Start = ($urandom_range(0, 2) == 0);
      A     = W'($urandom);
      B     = W'($urandom);
      Cin   = 1'($urandom);
      Reset = ($urandom_range(0, 80) == 0);
    end
    @(negedge Clk);
    Start = 1'b0;
    Reset = 1'b0;
    repeat (W + 3) @(negedge Clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder that accepts two parallel operands and a carry-in, then adds them least-significant bit first through a single FA cell. The carry is held in a flip-flop between cycles. The parallel result, carry-out and signed overflow are presented after a fixed N-cycle pass. It sits directly upstream of the FA cell: it feeds the cell's A/B/Cin inputs every cycle and consumes its Sum/Cout. Its purpose is to trade N adders for one adder plus N cycles of latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request to begin an addition. Sampled only in IDLE or DONE.
- A  input  WIDTH  operand A, captured on the cycle Start is accepted.
- B  input  WIDTH  operand B, captured on the cycle Start is accepted.
- Cin  input  1  carry-in, captured on the cycle Start is accepted.
- Busy  output  1  high while in state ADD.
- Done  output  1  one-cycle pulse when the result becomes valid.
- Sum  output  WIDTH  registered result; holds its value until the next completion.
- Cout  output  1  carry out of the MSB; registered with Sum.
- Overflow  output  1  two's-complement overflow, equal to carry-into-MSB XOR Cout; registered with Sum.

## Operation
- State machine: IDLE, ADD, DONE.
  - IDLE: Start=1 → load a_sh=A, b_sh=B, carry=Cin, bit counter=0, go to ADD.
  - ADD: each cycle, drive the FA with a_sh[0], b_sh[0] and carry.
    - Shift a_sh and b_sh right by one.
    - Shift the FA Sum into the MSB of acc (acc is shifted right).
    - carry ← FA Cout.
    - When counter=WIDTH-2, save the FA Cout into cmsb, because it is the carry into the MSB.
    - When counter=WIDTH-1, go to DONE; otherwise increment the counter.
  - Transition into DONE: Sum ← final acc, Cout ← final carry, Overflow ← cmsb XOR final carry.
  - DONE: Done=1 for exactly one cycle.
    - Start=1 → accepted exactly as in IDLE, going to ADD, so back-to-back operations are allowed.
    - Otherwise → IDLE.
- Start in ADD is ignored, and the operands are not re-sampled.
- Sum, Cout and Overflow change only on entry to DONE. They are stable for the whole of ADD.
- Arithmetic: {Cout,Sum} = A + B + Cin, computed modulo 2^(WIDTH+1).
- Reset (any state, including mid-ADD):
  - State ← IDLE.
  - Busy=0, Done=0, Sum=0, Cout=0, Overflow=0.
  - Shift registers, carry and counter are cleared.
  - A partial result is discarded and no Done is produced.
- Reset takes priority over Start in the same cycle.

## Timing
- Start accepted at rising edge k. The FSM is in ADD for edges k+1 through k+WIDTH, one bit per edge.
- Busy is high from after edge k until edge k+WIDTH.
- Done and new Sum/Cout/Overflow are visible after edge k+WIDTH. Done is low again after edge k+WIDTH+1 unless a new operation completes.
- Latency from Start to Done is WIDTH+1 cycles. Maximum throughput is one result per WIDTH+1 cycles.
- The FA path is combinational within one cycle; there is no pipeline stage inside the FA.

## Structure
- Package serial_adder_pkg:
  - State typedef IDLE=2'b00, ADD=2'b01, DONE=2'b10.
  - Default WIDTH constant.
- Sub-module: one instance of the team's existing FA full-adder cell (ports A, B, Cin, Sum, Cout). No other arithmetic in the datapath.
- Counter width: $clog2(WIDTH).

## Test plan
- Reset, then A=0x35, B=0x4A, Cin=0, Start for one cycle → Busy for 8 cycles, Done at Start+9, Sum=0x7F, Cout=0, Overflow=0.
- A=0xFF, B=0x01, Cin=0 → Sum=0x00, Cout=1, Overflow=0. Then A=0x7F, B=0x01 → Sum=0x80, Cout=0, Overflow=1.
- A=0x80, B=0x80, Cin=0 → Sum=0x00, Cout=1, Overflow=1. Then A=0xFF, B=0xFF, Cin=1 → Sum=0xFF, Cout=1, Overflow=0.
- Start held high during ADD with A and B changed to 0x00 → ignored; the result is from the first operands. Start high in the Done cycle with new operands → the second result follows exactly 9 cycles later.
- Reset asserted after 4 bits of an operation → next cycle all outputs 0, no Done pulse. A fresh Start with 0x12+0x34 → Sum=0x46.
- Check Sum throughout ADD → Sum holds the previous result until the Done edge.
